// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the ID stage, the ALU issue stage and the ALU.
// master = upstream/downstream environment, slave = alu_issue_stage.
interface alu_issue_stage_if #(
   parameter int DW = 32,
   parameter int TW = 5
);
   // Both sides use strict valid/ready: a transfer happens on a rising edge
   // where valid and ready are both high; a producer holding valid keeps its
   // payload stable until that edge, and valid never depends on ready.
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_aluop;
   logic [5:0]    in_funct;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic [TW-1:0] in_rd;

   logic          out_valid;
   logic          out_ready;
   logic [3:0]    out_sel;
   logic [DW-1:0] out_a;
   logic [DW-1:0] out_b;
   logic [TW-1:0] out_rd;
   logic          out_illegal;

   modport master (
      output in_valid, in_aluop, in_funct, in_a, in_b, in_rd, out_ready,
      input  in_ready, out_valid, out_sel, out_a, out_b, out_rd, out_illegal
   );

   modport slave (
      input  in_valid, in_aluop, in_funct, in_a, in_b, in_rd, out_ready,
      output in_ready, out_valid, out_sel, out_a, out_b, out_rd, out_illegal
   );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes ALUOp/funct into ALU_SEL and buffers the op
// through a 2-entry skid buffer whose in_ready comes straight from a flop.
module alu_issue_stage #(
   parameter int DW = 32,
   parameter int TW = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   alu_issue_stage_if.slave    bus,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic          illegal;
      logic [3:0]    sel;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [TW-1:0] rd;
   } entry_t;

   state_t state;
   state_t state_next;
   logic   main_valid;
   logic   skid_valid;
   logic   in_xfer;
   logic   out_xfer;
   logic   load_main;
   logic   load_skid;
   logic   move_skid;
   logic   [3:0] dec_sel;
   logic   dec_illegal;
   entry_t in_entry;
   entry_t main_q;
   entry_t skid_q;

   // ALUOp/funct decode into the ALU_32bit select encoding
   always_comb begin
      dec_sel     = 4'd2;
      dec_illegal = 1'b0;
      case (bus.in_aluop)
         2'b00: dec_sel = 4'd2;
         2'b01: dec_sel = 4'd6;
         2'b11: dec_sel = 4'd1;
         default: begin
            case (bus.in_funct)
               6'h20, 6'h21: dec_sel = 4'd2;
               6'h22, 6'h23: dec_sel = 4'd6;
               6'h24:        dec_sel = 4'd0;
               6'h25:        dec_sel = 4'd1;
               6'h27:        dec_sel = 4'd12;
               6'h2A:        dec_sel = 4'd8;
               6'h2B:        dec_sel = 4'd7;
               default: begin
                  dec_sel     = 4'd2;
                  dec_illegal = 1'b1;
               end
            endcase
         end
      endcase
   end

   always_comb begin
      in_entry.illegal = dec_illegal;
      in_entry.sel     = dec_sel;
      in_entry.a       = bus.in_a;
      in_entry.b       = bus.in_b;
      in_entry.rd      = bus.in_rd;
   end

   assign bus.in_ready = !skid_valid;
   assign in_xfer      = bus.in_valid & !skid_valid;
   assign out_xfer     = main_valid & bus.out_ready;

   // State register; the valid bits are registered copies of the next state
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state      <= ST_EMPTY;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         state      <= state_next;
         main_valid <= (state_next != ST_EMPTY);
         skid_valid <= (state_next == ST_TWO);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_EMPTY: if (in_xfer) state_next = ST_ONE;
         ST_ONE: begin
            if (in_xfer && !out_xfer)      state_next = ST_TWO;
            else if (!in_xfer && out_xfer) state_next = ST_EMPTY;
         end
         ST_TWO:   if (out_xfer) state_next = ST_ONE;
         default:  state_next = ST_EMPTY;
      endcase
   end

   // Load strobes; a flush cycle loads nothing so the dropped op never lands
   always_comb begin
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      if (!flush) begin
         case (state)
            ST_EMPTY: load_main = in_xfer;
            ST_ONE: begin
               load_skid = in_xfer & !out_xfer;
               load_main = in_xfer & out_xfer;
            end
            ST_TWO:   move_skid = out_xfer;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main)      main_q <= in_entry;
         else if (move_skid) main_q <= skid_q;
         if (load_skid)      skid_q <= in_entry;
      end
   end

   assign bus.out_valid   = main_valid;
   assign bus.out_sel     = main_q.sel;
   assign bus.out_a       = main_q.a;
   assign bus.out_b       = main_q.b;
   assign bus.out_rd      = main_q.rd;
   assign bus.out_illegal = main_q.illegal;
   assign dbg_state       = state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: drivers push expected entries into a
// queue and a negedge monitor pops and compares every output transfer.
module tb_alu_issue_stage;
   localparam int DW = 32;
   localparam int TW = 5;
   localparam int EW = 1 + 4 + DW + DW + TW;
   localparam int NT = 13;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   logic [1:0] dbg_state;

   alu_issue_stage_if #(.DW(DW), .TW(TW)) bus();

   alu_issue_stage #(.DW(DW), .TW(TW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;
   int cyc      = 0;
   int c0;
   int p0;

   logic [1:0] t_aluop[NT];
   logic [5:0] t_funct[NT];
   logic [3:0] t_sel[NT];
   logic       t_ill[NT];

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0h required no output",
                     {bus.out_illegal, bus.out_sel, bus.out_a, bus.out_b, bus.out_rd});
         end else begin
            check("out_entry",
                  {bus.out_illegal, bus.out_sel, bus.out_a, bus.out_b, bus.out_rd},
                  exp_q.pop_front());
         end
         n_pops++;
      end
   end

   // driver: call at #1 after a posedge, returns #1 after the accepting edge
   task automatic send(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] rd);
      int waited = 0;
      bus.in_valid = 1'b1;
      bus.in_aluop = t_aluop[idx];
      bus.in_funct = t_funct[idx];
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_rd    = rd;
      @(negedge clk);
      while (!bus.in_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready 0 required 1");
      end else begin
         exp_q.push_back({t_ill[idx], t_sel[idx], a, b, rd});
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int waited = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && waited < 40) begin
         waited++;
         tick();
      end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      t_aluop[0]  = 2'b10; t_funct[0]  = 6'h20; t_sel[0]  = 4'd2;  t_ill[0]  = 1'b0;
      t_aluop[1]  = 2'b10; t_funct[1]  = 6'h22; t_sel[1]  = 4'd6;  t_ill[1]  = 1'b0;
      t_aluop[2]  = 2'b10; t_funct[2]  = 6'h24; t_sel[2]  = 4'd0;  t_ill[2]  = 1'b0;
      t_aluop[3]  = 2'b10; t_funct[3]  = 6'h25; t_sel[3]  = 4'd1;  t_ill[3]  = 1'b0;
      t_aluop[4]  = 2'b10; t_funct[4]  = 6'h27; t_sel[4]  = 4'd12; t_ill[4]  = 1'b0;
      t_aluop[5]  = 2'b10; t_funct[5]  = 6'h2B; t_sel[5]  = 4'd7;  t_ill[5]  = 1'b0;
      t_aluop[6]  = 2'b00; t_funct[6]  = 6'h3F; t_sel[6]  = 4'd2;  t_ill[6]  = 1'b0;
      t_aluop[7]  = 2'b01; t_funct[7]  = 6'h00; t_sel[7]  = 4'd6;  t_ill[7]  = 1'b0;
      t_aluop[8]  = 2'b11; t_funct[8]  = 6'h15; t_sel[8]  = 4'd1;  t_ill[8]  = 1'b0;
      t_aluop[9]  = 2'b10; t_funct[9]  = 6'h21; t_sel[9]  = 4'd2;  t_ill[9]  = 1'b0;
      t_aluop[10] = 2'b10; t_funct[10] = 6'h23; t_sel[10] = 4'd6;  t_ill[10] = 1'b0;
      t_aluop[11] = 2'b10; t_funct[11] = 6'h2A; t_sel[11] = 4'd8;  t_ill[11] = 1'b0;
      t_aluop[12] = 2'b10; t_funct[12] = 6'h00; t_sel[12] = 4'd2;  t_ill[12] = 1'b1;

      reset = 1'b1;
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_aluop  = 2'b00;
      bus.in_funct  = 6'h00;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_rd     = '0;
      bus.out_ready = 1'b0;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_fields", {bus.out_illegal, bus.out_sel, bus.out_a, bus.out_b, bus.out_rd}, 0);
      check("rst_state", dbg_state, 0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", bus.in_ready, 1);
      check("post_rst_out_valid", bus.out_valid, 0);
      tick();

      // slt decode with one-cycle latency
      bus.out_ready = 1'b1;
      send(11, 32'd5, 32'd7, 5'd3);
      check("lat_out_valid", bus.out_valid, 1);
      check("lat_out_sel", bus.out_sel, 8);
      wait_drain();

      // back-pressure: two ops fill the buffer, third held upstream
      bus.out_ready = 1'b0;
      send(2, 32'h1111_0001, 32'h2222_0001, 5'd1);
      send(3, 32'h1111_0002, 32'h2222_0002, 5'd2);
      check("full_state", dbg_state, 2);
      check("full_in_ready", bus.in_ready, 0);
      fork
         send(4, 32'h1111_0003, 32'h2222_0003, 5'd4);
      join_none
      @(negedge clk);
      check("held_in_ready", bus.in_ready, 0);
      check("held_out_sel", bus.out_sel, 0);
      check("held_out_a", bus.out_a, 32'h1111_0001);
      tick();
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("drain0_valid", bus.out_valid, 1);
      check("drain0_sel", bus.out_sel, 0);
      @(negedge clk);
      check("drain1_valid", bus.out_valid, 1);
      check("drain1_sel", bus.out_sel, 1);
      @(negedge clk);
      check("drain2_valid", bus.out_valid, 1);
      check("drain2_sel", bus.out_sel, 12);
      tick();
      wait_drain();

      // streaming: one op accepted and emitted per cycle
      bus.out_ready = 1'b1;
      c0 = cyc;
      p0 = n_pops;
      for (int i = 0; i < 40; i++) begin
         send(i % NT, 32'hA000_0000 + i, 32'h0F0F_0000 ^ i, TW'(i));
      end
      check("stream_in_cycles", cyc - c0, 40);
      @(negedge clk);
      #1;
      check("stream_out_count", n_pops - p0, 40);
      tick();
      wait_drain();

      // flush in ONE with a concurrent input: both dropped
      bus.out_ready = 1'b0;
      send(0, 32'hBEEF_0001, 32'h1, 5'd9);
      bus.in_valid = 1'b1;
      bus.in_aluop = 2'b01;
      bus.in_a     = 32'hDEAD_0001;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("flush1_out_valid", bus.out_valid, 0);
      check("flush1_in_ready", bus.in_ready, 1);
      check("flush1_state", dbg_state, 0);
      tick();

      // flush in TWO with in_valid high
      send(5, 32'hC0DE_0001, 32'h2, 5'd10);
      send(6, 32'hC0DE_0002, 32'h3, 5'd11);
      check("flush2_pre_state", dbg_state, 2);
      bus.in_valid = 1'b1;
      bus.in_aluop = 2'b00;
      bus.in_a     = 32'hDEAD_0002;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("flush2_out_valid", bus.out_valid, 0);
      check("flush2_in_ready", bus.in_ready, 1);
      check("flush2_data_kept", bus.out_a, 32'hC0DE_0001);
      tick();
      bus.out_ready = 1'b1;
      p0 = n_pops;
      repeat (4) tick();
      check("flush2_no_emit", n_pops - p0, 0);

      // illegal funct then aluop 11
      send(12, 32'h0000_00AA, 32'h0000_00BB, 5'd12);
      send(8, 32'h0000_00CC, 32'h0000_00DD, 5'd13);
      wait_drain();

      // reset mid-operation discards buffered ops
      bus.out_ready = 1'b0;
      send(1, 32'h5555_0001, 32'h1, 5'd14);
      send(7, 32'h5555_0002, 32'h2, 5'd15);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_out_a", bus.out_a, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      tick();
      bus.out_ready = 1'b1;
      p0 = n_pops;
      repeat (4) tick();
      check("midrst_no_emit", n_pops - p0, 0);

      check("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
